sync_fifo_flex: RTL and testbench
=================================

# sync_fifo_flex

Single-clock, parametrised FIFO: the synchronous successor to our dual-clock FIFO, for use where producer and consumer share one clock. Adds fill-level count, runtime-programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable read mode: registered read or first-word-fall-through (FWFT). Sits between datapath stages as an elastic buffer, and as a status source for flow control.

## Interface
Parameters:
- DSIZE, 8, data width in bits
- ASIZE, 4, address width; depth DEPTH = 1<<ASIZE entries
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
- clk  input  1  single clock; all state updates on posedge clk
- rst  input  1  asynchronous, active-low reset
- wdata  input  DSIZE  write data
- winc  input  1  write request
- rinc  input  1  read request
- af_thresh  input  ASIZE+1  almost-full threshold (quasi-static)
- ae_thresh  input  ASIZE+1  almost-empty threshold (quasi-static)
- clr_err  input  1  clears overflow/underflow
- rdata  output  DSIZE  read data
- rvalid  output  1  rdata valid qualifier
- full, empty  output  1  occupancy flags
- almost_full, almost_empty  output  1  threshold flags
- count  output  ASIZE+1  entries held, 0..DEPTH
- overflow, underflow  output  1  sticky error flags

## Operation
- Pointers wptr and rptr are ASIZE+1 bits wide. Memory is indexed by ptr[ASIZE-1:0]. The MSB distinguishes wrap laps.
- Write accepted (wacc) = winc && !full: store wdata at mem[wptr[ASIZE-1:0]] and increment wptr.
- Read accepted (racc) = rinc && !empty: increment rptr.
- Gating uses the current-cycle flags only:
  - winc with rinc while full: read accepted, write rejected.
  - winc with rinc while empty: write accepted, read rejected.
  - Otherwise simultaneous wacc and racc both proceed, and count is unchanged.
- count = wptr - rptr, modulo 2^(ASIZE+1).
- empty = (wptr == rptr).
- full = low ASIZE bits equal and MSBs differ.
- almost_full = (count >= af_thresh); almost_empty = (count <= ae_thresh). Both are unsigned compares.
- overflow sets on winc && full; underflow sets on rinc && empty.
  - Both hold until clr_err.
  - If set and clear occur in the same cycle, set wins.
- FWFT=0:
  - On racc, rdata <= mem[rptr[ASIZE-1:0]] is registered and rvalid pulses high for one cycle.
  - Otherwise rdata holds its last value and rvalid = 0.
- FWFT=1:
  - rdata = mem[rptr[ASIZE-1:0]] (combinational from registered memory/pointer), rvalid = !empty.
  - rinc acknowledges the displayed word; the next word appears the cycle after.
- Memory contents are not reset. Only pointers, output registers and sticky flags are reset.

## Timing
- Reset (rst low, asynchronous, any time including mid-transfer) gives:
  - wptr = rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1.
  - almost_full = (af_thresh == 0), rdata = 0 (FWFT=0 register), rvalid = 0, overflow = underflow = 0.
  - Data held before reset is lost.
- Reset release is synchronous to clk; first accepted op is on the first rising edge with rst high.
- Flags and count derive from registered pointers and change one cycle after the accepting edge.
- Write-to-empty deassertion: 1 cycle.
- Write-to-read latency:
  - FWFT=1: word visible on rdata the cycle after the write edge.
  - FWFT=0: 2 edges (the write edge, then the racc edge); rvalid is high in the cycle after racc.
- Back-to-back: one write and one read per cycle sustained indefinitely with no bubble at 0 < count < DEPTH.
- Wrap-around: pointers roll from 2^(ASIZE+1)-1 to 0 with no flag glitch. full and empty remain exact across laps.
- Threshold changes take effect combinationally on the flags. Values above DEPTH are legal: almost_full then never asserts, and almost_empty is always high.

## Test plan
- Reset then idle, DEPTH=16 → empty=1, full=0, count=0, rvalid=0. Assert rst low mid-fill at count=7 → count=0 and empty=1 immediately, without waiting for a clock edge.
- Write 16 words 0x00..0x0F, then a 17th (0xAA) → full=1 at count=16, 0xAA dropped, overflow=1. Read all 16 → 0x00..0x0F in order, then empty=1. Pulse clr_err → overflow=0.
- Read while empty → underflow=1, rptr unchanged, count=0. clr_err and rinc in the same cycle while empty → underflow stays 1.
- Simultaneous winc+rinc:
  - at count=5 → count stays 5, data order preserved;
  - at full → count 16→15, write dropped, overflow=1;
  - at empty → count 0→1, underflow=1.
- af_thresh=12, ae_thresh=3:
  - fill 0→16 → almost_empty high for count≤3, almost_full high for count≥12;
  - change af_thresh to 20 → almost_full=0.
- Wrap: 40 cycles of continuous write+read with ramp data, FWFT=0 and FWFT=1 builds:
  - no data loss or duplication, no flag glitch;
  - FWFT=0 shows rvalid one cycle after each racc;
  - FWFT=1 shows rdata equal to the head word whenever empty=0.

Source files
------------

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with fill-level count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// a read port that is either registered (FWFT=0) or first-word-fall-through.
module sync_fifo_flex #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4,
  parameter int FWFT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic [ASIZE:0]   af_thresh,
  input  logic [ASIZE:0]   ae_thresh,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  logic [DSIZE-1:0] mem [0:(1<<ASIZE)-1];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic             wacc;
  logic             racc;

  // Occupancy, threshold flags and op acceptance all come from the registered
  // pointers; the extra pointer MSB tells a full FIFO apart from an empty one.
  always_comb begin
    count        = wptr - rptr;
    empty        = (wptr == rptr);
    full         = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) && (wptr[ASIZE] != rptr[ASIZE]);
    almost_full  = (count >= af_thresh);
    almost_empty = (count <= ae_thresh);
    wacc         = winc && !full;
    racc         = rinc && !empty;
  end

  // Pointer advance on accepted operations; both may move in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wacc) wptr <= wptr + 1'b1;
      if (racc) rptr <= rptr + 1'b1;
    end
  end

  // Storage array is deliberately left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wacc) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && full)  overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (rinc && empty) underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always on display; rinc just acknowledges it.
      always_comb begin
        rdata  = mem[rptr[ASIZE-1:0]];
        rvalid = !empty;
      end
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_q;
      logic             rvalid_q;

      // Registered read: data captured on the accepting edge, rvalid pulses once.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= racc;
          if (racc) rdata_q <= mem[rptr[ASIZE-1:0]];
        end
      end

      // Expose the read register on the output port.
      always_comb begin
        rdata  = rdata_q;
        rvalid = rvalid_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: drives one registered-read and one FWFT instance with the
// same stimulus and checks both against a queue-based reference model plus
// a table of hand-derived vectors and explicit corner-case sequences.
module tb_sync_fifo_flex;

  logic       clk;
  logic       rst;
  logic [7:0] wdata;
  logic       winc;
  logic       rinc;
  logic       clr_err;
  logic [4:0] af_thresh;
  logic [4:0] ae_thresh;

  logic [7:0] rdata_o [2];
  logic       rvalid_o [2];
  logic       full_o [2];
  logic       empty_o [2];
  logic       af_o [2];
  logic       ae_o [2];
  logic [4:0] count_o [2];
  logic       ovf_o [2];
  logic       unf_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  logic       ovf_m;
  logic       unf_m;
  logic [7:0] last_rd;

  typedef struct {
    logic       w;
    logic       r;
    logic       c;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs [7];

  sync_fifo_flex #(.DSIZE(8), .ASIZE(4), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
    .rdata(rdata_o[0]), .rvalid(rvalid_o[0]), .full(full_o[0]), .empty(empty_o[0]),
    .almost_full(af_o[0]), .almost_empty(ae_o[0]), .count(count_o[0]),
    .overflow(ovf_o[0]), .underflow(unf_o[0])
  );

  sync_fifo_flex #(.DSIZE(8), .ASIZE(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
    .rdata(rdata_o[1]), .rvalid(rvalid_o[1]), .full(full_o[1]), .empty(empty_o[1]),
    .almost_full(af_o[1]), .almost_empty(ae_o[1]), .count(count_o[1]),
    .overflow(ovf_o[1]), .underflow(unf_o[1])
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare status outputs of both instances against the model occupancy.
  task automatic checkFlags();
    int n;
    n = q.size();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("count[%0d]", i), 32'(count_o[i]), 32'(n));
      checkOutput($sformatf("empty[%0d]", i), 32'(empty_o[i]), 32'(n == 0));
      checkOutput($sformatf("full[%0d]", i), 32'(full_o[i]), 32'(n == 16));
      checkOutput($sformatf("almost_full[%0d]", i), 32'(af_o[i]), 32'(n >= int'(af_thresh)));
      checkOutput($sformatf("almost_empty[%0d]", i), 32'(ae_o[i]), 32'(n <= int'(ae_thresh)));
      checkOutput($sformatf("overflow[%0d]", i), 32'(ovf_o[i]), 32'(ovf_m));
      checkOutput($sformatf("underflow[%0d]", i), 32'(unf_o[i]), 32'(unf_m));
    end
  endtask

  // One clock cycle of stimulus; called at #1 after a rising edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d, input logic c);
    int         n;
    logic       wa;
    logic       ra;
    logic [7:0] head;
    n  = q.size();
    wa = w && (n != 16);
    ra = r && (n != 0);
    checkOutput("fwft_rvalid", 32'(rvalid_o[1]), 32'(n != 0));
    if (n != 0) checkOutput("fwft_head", 32'(rdata_o[1]), 32'(q[0]));
    winc    = w;
    rinc    = r;
    wdata   = d;
    clr_err = c;
    head = 8'h00;
    if (ra) begin
      head    = q.pop_front();
      last_rd = head;
    end
    if (wa) q.push_back(d);
    ovf_m = (w && n == 16) ? 1'b1 : (c ? 1'b0 : ovf_m);
    unf_m = (r && n == 0)  ? 1'b1 : (c ? 1'b0 : unf_m);
    @(posedge clk);
    #1;
    winc    = 1'b0;
    rinc    = 1'b0;
    clr_err = 1'b0;
    checkOutput("reg_rvalid", 32'(rvalid_o[0]), 32'(ra));
    checkOutput("reg_rdata", 32'(rdata_o[0]), 32'(last_rd));
    checkFlags();
  endtask

  task automatic doWrites(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'(base + 8'(i)), 1'b0);
  endtask

  task automatic doReads(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  // Expected state while reset is asserted, checked with no clock edge in between.
  task automatic checkReset();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst_count[%0d]", i), 32'(count_o[i]), 32'd0);
      checkOutput($sformatf("rst_empty[%0d]", i), 32'(empty_o[i]), 32'd1);
      checkOutput($sformatf("rst_full[%0d]", i), 32'(full_o[i]), 32'd0);
      checkOutput($sformatf("rst_ae[%0d]", i), 32'(ae_o[i]), 32'd1);
      checkOutput($sformatf("rst_af[%0d]", i), 32'(af_o[i]), 32'(af_thresh == 5'd0));
      checkOutput($sformatf("rst_rvalid[%0d]", i), 32'(rvalid_o[i]), 32'd0);
      checkOutput($sformatf("rst_ovf[%0d]", i), 32'(ovf_o[i]), 32'd0);
      checkOutput($sformatf("rst_unf[%0d]", i), 32'(unf_o[i]), 32'd0);
    end
    checkOutput("rst_rdata_reg", 32'(rdata_o[0]), 32'd0);
    q.delete();
    ovf_m   = 1'b0;
    unf_m   = 1'b0;
    last_rd = 8'h00;
  endtask

  initial begin
    rst       = 1'b1;
    winc      = 1'b0;
    rinc      = 1'b0;
    clr_err   = 1'b0;
    wdata     = 8'h00;
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    ovf_m     = 1'b0;
    unf_m     = 1'b0;
    last_rd   = 8'h00;

    // Power-on reset, checked before any clock edge.
    #2 rst = 1'b0;
    #2 checkReset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Hand-derived vectors: underflow, set-beats-clear, simultaneous op at empty.
    vecs[0] = '{w:1'b0, r:1'b0, c:1'b0, d:8'h00, cnt:5'd0, ovf:1'b0, unf:1'b0};
    vecs[1] = '{w:1'b0, r:1'b1, c:1'b0, d:8'h00, cnt:5'd0, ovf:1'b0, unf:1'b1};
    vecs[2] = '{w:1'b0, r:1'b1, c:1'b1, d:8'h00, cnt:5'd0, ovf:1'b0, unf:1'b1};
    vecs[3] = '{w:1'b0, r:1'b0, c:1'b1, d:8'h00, cnt:5'd0, ovf:1'b0, unf:1'b0};
    vecs[4] = '{w:1'b1, r:1'b1, c:1'b0, d:8'h55, cnt:5'd1, ovf:1'b0, unf:1'b1};
    vecs[5] = '{w:1'b0, r:1'b0, c:1'b1, d:8'h00, cnt:5'd1, ovf:1'b0, unf:1'b0};
    vecs[6] = '{w:1'b0, r:1'b1, c:1'b0, d:8'h00, cnt:5'd0, ovf:1'b0, unf:1'b0};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].w, vecs[i].r, vecs[i].d, vecs[i].c);
      checkOutput($sformatf("vec%0d_count", i), 32'(count_o[0]), 32'(vecs[i].cnt));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf_o[0]), 32'(vecs[i].ovf));
      checkOutput($sformatf("vec%0d_unf", i), 32'(unf_o[0]), 32'(vecs[i].unf));
    end
    checkOutput("vec6_rdata", 32'(rdata_o[0]), 32'h55);

    // Fill to full, then a rejected 17th write.
    doWrites(16, 8'h00);
    checkOutput("full_at16", 32'(full_o[0]), 32'd1);
    checkOutput("af_at16", 32'(af_o[0]), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0);
    checkOutput("ovf_after17", 32'(ovf_o[0]), 32'd1);
    checkOutput("count_after17", 32'(count_o[0]), 32'd16);
    doReads(16);
    checkOutput("empty_after_drain", 32'(empty_o[0]), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("ovf_cleared", 32'(ovf_o[0]), 32'd0);

    // Simultaneous write+read at full: read wins, write dropped.
    doWrites(16, 8'h20);
    applyStimulus(1'b1, 1'b1, 8'hBB, 1'b0);
    checkOutput("full_rw_count", 32'(count_o[0]), 32'd15);
    checkOutput("full_rw_ovf", 32'(ovf_o[1]), 32'd1);
    checkOutput("full_rw_rdata", 32'(rdata_o[0]), 32'h20);

    // Simultaneous write+read mid-range keeps count steady.
    doReads(10);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h40 + 8'(i)), 1'b0);
      checkOutput("mid_rw_count", 32'(count_o[0]), 32'd5);
    end
    doReads(5);

    // Threshold reprogramming above DEPTH.
    doWrites(16, 8'h50);
    af_thresh = 5'd20;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("af_thresh20", 32'(af_o[0]), 32'd0);
    ae_thresh = 5'd20;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("ae_thresh20", 32'(ae_o[1]), 32'd1);
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    doReads(16);

    // Asynchronous reset in the middle of a fill.
    doWrites(7, 8'h70);
    checkOutput("count_before_rst", 32'(count_o[0]), 32'd7);
    #4 rst = 1'b0;
    #1 checkReset();
    @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    // Sustained write+read across pointer wrap with ramp data.
    doWrites(3, 8'h80);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 8'(8'h90 + 8'(i)), 1'b0);
    doReads(3);
    checkOutput("wrap_last_word", 32'(rdata_o[0]), 32'hB7);
    checkOutput("wrap_empty", 32'(empty_o[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
